// File: rtl/dino_pkg.sv
// Shared encodings for the dino player controller: FSM states, tick strobe indices and defaults.
package dino_pkg;

    typedef enum logic [2:0] {
        ST_RESTART   = 3'b000,
        ST_JUMPING   = 3'b001,
        ST_RUN1      = 3'b010,
        ST_RUN2      = 3'b011,
        ST_DUCKING   = 3'b100,
        ST_GAME_OVER = 3'b101
    } state_t;

    localparam int TICK_FRAME   = 0;
    localparam int TICK_PHYS    = 1;
    localparam int DEF_LIVES    = 3;
    localparam int DEF_JUMP_VEL = 7;

    // States in which the player can be hit
    function automatic logic is_playing(input state_t s);
        return (s == ST_JUMPING) || (s == ST_RUN1) || (s == ST_RUN2) || (s == ST_DUCKING);
    endfunction

endpackage

// File: rtl/player_jump_physics.sv
// Jump physics: owns height, signed velocity and the UP-hold budget; reports the landing tick.
module player_jump_physics
    import dino_pkg::*;
#(
    parameter int POS_W      = 6,
    parameter int JUMP_VEL   = DEF_JUMP_VEL,
    parameter int HOLD_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic             active,
    input  logic             freeze,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    output logic [POS_W-1:0] position,
    output logic             jump_done
);

    localparam int VW   = POS_W + 1;
    localparam int SW   = POS_W + 2;
    localparam int HW   = $clog2(HOLD_TICKS + 1);
    localparam int PMAX = (1 << POS_W) - 1;

    localparam logic signed [SW-1:0] POS_ZERO_S = '0;
    localparam logic signed [SW-1:0] POS_MAX_S  = SW'(PMAX);
    localparam logic signed [VW-1:0] VEL_ZERO_S = '0;
    localparam logic signed [VW:0]   VEL_MIN_S  = (VW+1)'(-PMAX);

    logic [POS_W-1:0]     pos_r;
    logic signed [VW-1:0] vel_r;
    logic [HW-1:0]        hold_r;
    logic signed [SW-1:0] next_s;
    logic signed [VW:0]   vel_next_s;
    logic signed [VW:0]   vel_floor_s;
    logic [1:0]           grav_s;

    // Candidate height, gravity selection and floored velocity for this physics tick
    always_comb begin
        next_s = $signed({2'b00, pos_r}) + $signed({vel_r[VW-1], vel_r});
        if (down) begin
            grav_s = 2'd2;
        end else if (up && (vel_r > VEL_ZERO_S) && (hold_r < HW'(HOLD_TICKS))) begin
            grav_s = 2'd0;
        end else begin
            grav_s = 2'd1;
        end
        vel_next_s = $signed({vel_r[VW-1], vel_r}) - $signed({{(VW-1){1'b0}}, grav_s});
        if (vel_next_s < VEL_MIN_S) begin
            vel_floor_s = VEL_MIN_S;
        end else begin
            vel_floor_s = vel_next_s;
        end
        jump_done = active && tick && (next_s <= POS_ZERO_S);
    end

    // Physics state: launch wins over a same-cycle tick; clear whenever not jumping or frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r  <= '0;
            vel_r  <= '0;
            hold_r <= '0;
        end else if (launch) begin
            vel_r  <= VW'(JUMP_VEL);
            hold_r <= '0;
        end else if (active) begin
            // Releasing UP spends the rest of the hold budget so it cannot re-arm
            if (!up) begin
                hold_r <= HW'(HOLD_TICKS);
            end
            if (tick) begin
                if (next_s <= POS_ZERO_S) begin
                    pos_r <= '0;
                    vel_r <= '0;
                end else begin
                    if (next_s >= POS_MAX_S) begin
                        pos_r <= POS_W'(PMAX);
                    end else begin
                        pos_r <= next_s[POS_W-1:0];
                    end
                    vel_r <= vel_floor_s[VW-1:0];
                    if (grav_s == 2'd0) begin
                        hold_r <= hold_r + HW'(1);
                    end
                end
            end
        end else if (!freeze) begin
            pos_r  <= '0;
            vel_r  <= '0;
            hold_r <= '0;
        end
    end

    assign position = pos_r;

endmodule

// File: rtl/player_controller_lives.sv
// Dino player controller: game FSM, lives and invulnerability counters, event pulse decode;
// jump physics lives in player_jump_physics.
module player_controller_lives
    import dino_pkg::*;
#(
    parameter int POS_W        = 6,
    parameter int JUMP_VEL     = DEF_JUMP_VEL,
    parameter int HOLD_TICKS   = 4,
    parameter int LIVES        = DEF_LIVES,
    parameter int INVULN_TICKS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 game_tick,
    input  logic                       button_start,
    input  logic                       button_up,
    input  logic                       button_down,
    input  logic                       crash,
    output logic [POS_W-1:0]           player_position,
    output logic [$clog2(LIVES+1)-1:0] lives_left,
    output logic                       invulnerable,
    output logic [2:0]                 game_state,
    output logic                       game_start_pulse,
    output logic                       game_over_pulse,
    output logic                       jump_pulse,
    output logic                       hit_pulse
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int IW = $clog2(INVULN_TICKS + 1);

    state_t        state_r;
    logic [LW-1:0] lives_r;
    logic [IW-1:0] inv_r;
    logic          tick0_s;
    logic          tick1_s;
    logic          acc_s;
    logic          fatal_s;
    logic          start_ok_s;
    logic          launch_s;
    logic          active_s;
    logic          freeze_s;
    logic          jump_done_s;

    // Crash acceptance, start acceptance and physics control decode
    always_comb begin
        tick0_s    = game_tick[TICK_FRAME];
        tick1_s    = game_tick[TICK_PHYS];
        acc_s      = crash && (inv_r == '0) && is_playing(state_r);
        fatal_s    = acc_s && (lives_r == LW'(1));
        start_ok_s = tick0_s && button_start &&
                     ((state_r == ST_RESTART) || (state_r == ST_GAME_OVER));
        launch_s   = !fatal_s && tick0_s &&
                     (((state_r == ST_RESTART) && button_start) ||
                      (((state_r == ST_RUN1) || (state_r == ST_RUN2)) && !button_down && button_up));
        active_s   = (state_r == ST_JUMPING) && !fatal_s;
        freeze_s   = (state_r == ST_GAME_OVER) && !start_ok_s;
    end

    player_jump_physics #(
        .POS_W      (POS_W),
        .JUMP_VEL   (JUMP_VEL),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_physics (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch_s),
        .active    (active_s),
        .freeze    (freeze_s),
        .tick      (tick1_s),
        .up        (button_up),
        .down      (button_down),
        .position  (player_position),
        .jump_done (jump_done_s)
    );

    // Game FSM; a fatal hit overrides every other transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RESTART;
        end else if (fatal_s) begin
            state_r <= ST_GAME_OVER;
        end else begin
            case (state_r)
                ST_RESTART:   if (start_ok_s) state_r <= ST_JUMPING;
                ST_RUN1, ST_RUN2: begin
                    if (tick0_s) begin
                        if (button_down)    state_r <= ST_DUCKING;
                        else if (button_up) state_r <= ST_JUMPING;
                        else                state_r <= (state_r == ST_RUN1) ? ST_RUN2 : ST_RUN1;
                    end
                end
                ST_DUCKING:   if (tick0_s && !button_down) state_r <= ST_RUN1;
                ST_JUMPING:   if (jump_done_s) state_r <= ST_RUN1;
                ST_GAME_OVER: if (start_ok_s) state_r <= ST_RUN1;
                default:      state_r <= ST_RESTART;
            endcase
        end
    end

    // Lives and invulnerability window; a hit reloads the window ahead of the frame-tick decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            lives_r <= LW'(LIVES);
            inv_r   <= '0;
        end else if (start_ok_s) begin
            lives_r <= LW'(LIVES);
            inv_r   <= '0;
        end else if (fatal_s) begin
            lives_r <= '0;
        end else if (acc_s) begin
            lives_r <= lives_r - LW'(1);
            inv_r   <= IW'(INVULN_TICKS);
        end else if (tick0_s && (inv_r != '0)) begin
            inv_r   <= inv_r - IW'(1);
        end
    end

    assign lives_left       = lives_r;
    assign invulnerable     = (inv_r != '0);
    assign game_state       = state_r;
    assign game_start_pulse = start_ok_s;
    assign game_over_pulse  = fatal_s;
    assign jump_pulse       = launch_s;
    assign hit_pulse        = acc_s;

endmodule

// File: tb/tb_player_controller_lives.sv
// Directed scenarios plus randomized play checked against an integer reference model of the game.
module tb_player_controller_lives;

    localparam int POS_W = 6, JUMP_VEL = 7, HOLD_TICKS = 4, LIVES = 3, INVULN_TICKS = 32;
    localparam int PMAX = 63;
    localparam int S_RESTART = 0, S_JUMP = 1, S_RUN1 = 2, S_RUN2 = 3, S_DUCK = 4, S_OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] game_tick = 2'b00;
    logic       button_start = 1'b0, button_up = 1'b0, button_down = 1'b0, crash = 1'b0;
    logic [POS_W-1:0] player_position;
    logic [1:0] lives_left;
    logic       invulnerable;
    logic [2:0] game_state;
    logic       game_start_pulse, game_over_pulse, jump_pulse, hit_pulse;

    player_controller_lives #(
        .POS_W(POS_W), .JUMP_VEL(JUMP_VEL), .HOLD_TICKS(HOLD_TICKS),
        .LIVES(LIVES), .INVULN_TICKS(INVULN_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .game_tick(game_tick), .button_start(button_start),
        .button_up(button_up), .button_down(button_down), .crash(crash),
        .player_position(player_position), .lives_left(lives_left), .invulnerable(invulnerable),
        .game_state(game_state), .game_start_pulse(game_start_pulse),
        .game_over_pulse(game_over_pulse), .jump_pulse(jump_pulse), .hit_pulse(hit_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;
    int last_pulses = 0;   // {start, over, jump, hit}

    // reference model state
    int m_st, m_pos, m_vel, m_held, m_lives, m_inv;
    bit m_hold_live;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: drive inputs after negedge, compare against the model, advance the model.
    task automatic cycle(input logic [1:0] tk, input logic st, input logic up, input logic dn,
                         input logic cr, input logic r);
        bit playing, acc, fatal, sok, ejump, landed, nlive;
        int nst, npos, nvel, nheld, nlives, ninv, nxt, g;
        rst = r; game_tick = tk; button_start = st; button_up = up; button_down = dn; crash = cr;
        #1;
        playing = (m_st >= S_JUMP) && (m_st <= S_DUCK);
        acc     = cr && (m_inv == 0) && playing;
        fatal   = acc && (m_lives == 1);
        sok     = tk[0] && st && ((m_st == S_RESTART) || (m_st == S_OVER));
        ejump   = !fatal && tk[0] && (((m_st == S_RESTART) && st) ||
                  (((m_st == S_RUN1) || (m_st == S_RUN2)) && !dn && up));
        last_pulses = int'({game_start_pulse, game_over_pulse, jump_pulse, hit_pulse});
        if (armed) begin
            chk("state", int'(game_state), m_st);
            chk("position", int'(player_position), m_pos);
            chk("lives", int'(lives_left), m_lives);
            chk("invulnerable", int'(invulnerable), int'(m_inv != 0));
            chk("start_pulse", int'(game_start_pulse), int'(sok));
            chk("over_pulse", int'(game_over_pulse), int'(fatal));
            chk("jump_pulse", int'(jump_pulse), int'(ejump));
            chk("hit_pulse", int'(hit_pulse), int'(acc));
        end
        nst = m_st; npos = m_pos; nvel = m_vel; nheld = m_held; nlive = m_hold_live;
        nlives = m_lives; ninv = m_inv; landed = 1'b0;
        if (ejump) begin
            nvel = JUMP_VEL; nheld = 0; nlive = 1'b1;
        end else if ((m_st == S_JUMP) && !fatal) begin
            if (!up) nlive = 1'b0;
            if (tk[1]) begin
                nxt = m_pos + m_vel;
                if (nxt <= 0) begin
                    npos = 0; nvel = 0; landed = 1'b1;
                end else begin
                    npos = (nxt > PMAX) ? PMAX : nxt;
                    if (dn) g = 2;
                    else if (up && (m_vel > 0) && nlive && (m_held < HOLD_TICKS)) begin
                        g = 0; nheld = m_held + 1;
                    end else g = 1;
                    nvel = m_vel - g;
                    if (nvel < -PMAX) nvel = -PMAX;
                end
            end
        end else if (!((m_st == S_OVER) && !sok)) begin
            npos = 0; nvel = 0; nheld = 0;
        end
        if (fatal) nst = S_OVER;
        else case (m_st)
            S_RESTART: if (sok) nst = S_JUMP;
            S_RUN1, S_RUN2: if (tk[0]) nst = dn ? S_DUCK : (up ? S_JUMP : ((m_st == S_RUN1) ? S_RUN2 : S_RUN1));
            S_DUCK:    if (tk[0] && !dn) nst = S_RUN1;
            S_JUMP:    if (landed) nst = S_RUN1;
            S_OVER:    if (sok) nst = S_RUN1;
            default:   nst = S_RESTART;
        endcase
        if (sok) begin nlives = LIVES; ninv = 0; end
        else if (fatal) nlives = 0;
        else if (acc) begin nlives = m_lives - 1; ninv = INVULN_TICKS; end
        else if (tk[0] && (m_inv > 0)) ninv = m_inv - 1;
        if (r) begin
            m_st = S_RESTART; m_pos = 0; m_vel = 0; m_held = 0; m_hold_live = 1'b0;
            m_lives = LIVES; m_inv = 0; armed = 1'b1;
        end else begin
            m_st = nst; m_pos = npos; m_vel = nvel; m_held = nheld; m_hold_live = nlive;
            m_lives = nlives; m_inv = ninv;
        end
        @(negedge clk);
    endtask

    int t1_pos [15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
    int t2_pos [7]  = '{7, 14, 21, 28, 35, 41, 46};

    initial begin
        int peak, n_ticks;
        @(negedge clk);
        cycle(2'b00, 0, 0, 0, 0, 1);
        chk("rst_state", int'(game_state), S_RESTART);
        chk("rst_lives", int'(lives_left), LIVES);

        // T1: plain jump arc
        cycle(2'b01, 1, 0, 0, 0, 0);
        chk("t1_pulses", last_pulses, 4'b1010);
        chk("t1_jumping", int'(game_state), S_JUMP);
        for (int i = 0; i < 15; i++) begin
            cycle(2'b10, 0, 0, 0, 0, 0);
            chk("t1_pos", int'(player_position), t1_pos[i]);
        end
        chk("t1_landed", int'(game_state), S_RUN1);

        // T2: held UP reaches higher; DOWN lands sooner
        cycle(2'b01, 0, 1, 0, 0, 0);
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(2'b10, 0, 1, 0, 0, 0);
            chk("t2_pos", int'(player_position), t2_pos[i]);
        end
        for (int i = 0; i < 60 && game_state == 3'(S_JUMP); i++) begin
            if (int'(player_position) > peak) peak = int'(player_position);
            cycle(2'b10, 0, 1, 0, 0, 0);
        end
        chk("t2_peak_higher", int'(peak > 28), 1);
        chk("t2_landed", int'(game_state), S_RUN1);
        cycle(2'b01, 0, 1, 0, 0, 0);
        n_ticks = 0;
        for (int i = 0; i < 60 && game_state == 3'(S_JUMP); i++) begin
            cycle(2'b10, 0, 0, 1, 0, 0);
            n_ticks++;
        end
        chk("t2_fastfall_ticks", n_ticks, 8);

        // T3: non-fatal hit, grace window, second hit after window
        cycle(2'b00, 0, 0, 0, 1, 0);
        chk("t3_hit", last_pulses, 4'b0001);
        chk("t3_lives", int'(lives_left), 2);
        cycle(2'b00, 0, 0, 0, 1, 0);
        chk("t3_ignored", last_pulses, 4'b0000);
        for (int i = 0; i < 31; i++) cycle(2'b01, 0, 0, 0, 0, 0);
        chk("t3_still_invuln", int'(invulnerable), 1);
        cycle(2'b01, 0, 0, 0, 0, 0);
        chk("t3_window_over", int'(invulnerable), 0);
        cycle(2'b00, 0, 0, 0, 1, 0);
        chk("t3_lives1", int'(lives_left), 1);

        // T4: fatal hit beats a same-cycle jump
        for (int i = 0; i < 32; i++) cycle(2'b01, 0, 0, 0, 0, 0);
        cycle(2'b01, 0, 1, 0, 1, 0);
        chk("t4_pulses", last_pulses, 4'b0101);
        chk("t4_state", int'(game_state), S_OVER);
        chk("t4_lives", int'(lives_left), 0);

        // T5: restart from GAME_OVER only on a frame tick
        cycle(2'b00, 1, 0, 0, 0, 0);
        chk("t5_no_tick", int'(game_state), S_OVER);
        cycle(2'b01, 1, 0, 0, 0, 0);
        chk("t5_start_pulse", last_pulses, 4'b1000);
        chk("t5_state", int'(game_state), S_RUN1);
        chk("t5_lives", int'(lives_left), 3);
        chk("t5_pos", int'(player_position), 0);

        // T6: reset mid-jump
        cycle(2'b01, 0, 0, 0, 0, 0);
        cycle(2'b01, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(2'b10, 0, 0, 0, 0, 0);
        chk("t6_midair", int'(player_position), 18);
        cycle(2'b00, 0, 0, 0, 0, 1);
        chk("t6_state", int'(game_state), S_RESTART);
        chk("t6_pos", int'(player_position), 0);
        chk("t6_lives", int'(lives_left), 3);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] tk;
            tk[0] = ($urandom_range(0, 3) == 0);
            tk[1] = ($urandom_range(0, 2) == 0);
            cycle(tk, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
